// File: rtl/arc_datapath_p.sv
// Parametrised ARC datapath: register file with PC/temps/IR, 16-function ALU/shifter,
// condition-code PSR, and a valid/ready micro-op port with a memory-load wait state.
module arc_datapath_p #(
    parameter int W     = 32,
    parameter int NREG  = 32,
    parameter int NTEMP = 4,
    parameter int SW    = $clog2(NREG + NTEMP + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uop_valid,
    output logic          uop_ready,
    input  logic [SW-1:0] a_sel,
    input  logic [SW-1:0] b_sel,
    input  logic [SW-1:0] c_sel,
    input  logic          a_from_ir,
    input  logic          b_from_ir,
    input  logic          c_from_ir,
    input  logic          c_src_mem,
    input  logic [3:0]    alu_func,
    input  logic [W-1:0]  mem_data,
    input  logic          mem_valid,
    output logic          mem_req,
    output logic [W-1:0]  bus_a,
    output logic [W-1:0]  bus_b,
    output logic [W-1:0]  ir,
    output logic [3:0]    psr,
    output logic          state_dbg
);

    localparam int NTOT   = NREG + NTEMP + 2;
    localparam int IR_IDX = NTOT - 1;
    localparam int IW     = (SW > 5) ? SW : 5;
    localparam int SHW    = $clog2(W);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   pend_idx;
    logic [W-1:0]    rf [1:NTOT-1];

    logic [IW-1:0]   a_idx, b_idx, c_idx, wr_idx;
    logic [W-1:0]    alu_res, wr_data;
    logic [W:0]      add_full;
    logic            add_ovf;
    logic [3:0]      psr_next;
    logic            accept, wr_en, psr_we;

    // An IR field is a 5-bit register number, zero-extended into the select space.
    function automatic logic [IW-1:0] resolve(input logic [SW-1:0] sel,
                                              input logic          from_ir,
                                              input logic [4:0]    field);
        resolve = from_ir ? IW'(field) : IW'(sel);
    endfunction

    assign ir        = rf[IR_IDX];
    assign a_idx     = resolve(a_sel, a_from_ir, ir[18:14]);
    assign b_idx     = resolve(b_sel, b_from_ir, ir[4:0]);
    assign c_idx     = resolve(c_sel, c_from_ir, ir[29:25]);
    assign state_dbg = state;

    // r0 and out-of-range selects fall through to the zero default.
    always_comb begin
        bus_a = '0;
        bus_b = '0;
        for (int i = 1; i < NTOT; i++) begin
            if (a_idx == IW'(i)) bus_a = rf[i];
            if (b_idx == IW'(i)) bus_b = rf[i];
        end
    end

    assign add_full = {1'b0, bus_a} + {1'b0, bus_b};
    assign add_ovf  = (bus_a[W-1] == bus_b[W-1]) && (add_full[W-1] != bus_a[W-1]);

    always_comb begin
        alu_res = '0;
        case (alu_func)
            4'd0, 4'd5: alu_res = bus_a & bus_b;
            4'd1, 4'd6: alu_res = bus_a | bus_b;
            4'd2, 4'd7: alu_res = ~(bus_a | bus_b);
            4'd3, 4'd8: alu_res = add_full[W-1:0];
            4'd4:       alu_res = bus_a >> bus_b[SHW-1:0];
            4'd9:       alu_res = bus_a << 2;
            4'd10:      alu_res = bus_a << 10;
            4'd11:      alu_res = {{(W-13){1'b0}}, bus_a[12:0]};
            4'd12:      alu_res = {{(W-13){bus_a[12]}}, bus_a[12:0]};
            4'd13:      alu_res = bus_a + W'(1);
            4'd14:      alu_res = bus_a + W'(4);
            4'd15:      alu_res = $signed(bus_a) >>> 5;
        endcase
    end

    always_comb begin
        psr_next = {alu_res[W-1], (alu_res == '0), 2'b00};
        if (alu_func == 4'd3) psr_next[1:0] = {add_ovf, add_full[W]};
    end

    // Handshake: a micro-op transfers on any edge where uop_valid && uop_ready;
    // uop_ready depends only on state, never on uop_valid, and drops for the whole WAIT.
    assign uop_ready = (state == S_IDLE);
    assign accept    = uop_ready && uop_valid;
    assign mem_req   = (accept && c_src_mem) || (state == S_WAIT);
    assign wr_en     = (accept && (!c_src_mem || mem_valid)) || ((state == S_WAIT) && mem_valid);
    assign wr_idx    = (state == S_WAIT) ? pend_idx : c_idx;
    assign wr_data   = ((state == S_WAIT) || c_src_mem) ? mem_data : alu_res;
    assign psr_we    = accept && !c_src_mem && (alu_func <= 4'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pend_idx <= '0;
            psr      <= '0;
        end else begin
            if (psr_we) psr <= psr_next;
            case (state)
                S_IDLE: begin
                    if (accept && c_src_mem && !mem_valid) begin
                        pend_idx <= c_idx;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Writes to r0 and unmapped indices match no entry and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NTOT; i++) rf[i] <= '0;
        end else if (wr_en) begin
            for (int i = 1; i < NTOT; i++) begin
                if (wr_idx == IW'(i)) rf[i] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_arc_datapath_p.sv
// Randomised and directed bench for arc_datapath_p against an arithmetic reference model.
module tb_arc_datapath_p;

    localparam int W     = 32;
    localparam int NREG  = 32;
    localparam int NTEMP = 4;
    localparam int SW    = 6;
    localparam int NTOT  = NREG + NTEMP + 2;
    localparam int IRX   = NTOT - 1;
    localparam int NSEL  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uop_valid = 1'b0;
    logic          uop_ready;
    logic [SW-1:0] a_sel = '0, b_sel = '0, c_sel = '0;
    logic          a_from_ir = 1'b0, b_from_ir = 1'b0, c_from_ir = 1'b0;
    logic          c_src_mem = 1'b0;
    logic [3:0]    alu_func = '0;
    logic [W-1:0]  mem_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_req;
    logic [W-1:0]  bus_a, bus_b, ir;
    logic [3:0]    psr;
    logic          state_dbg;

    arc_datapath_p #(.W(W), .NREG(NREG), .NTEMP(NTEMP), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel),
        .a_from_ir(a_from_ir), .b_from_ir(b_from_ir), .c_from_ir(c_from_ir),
        .c_src_mem(c_src_mem), .alu_func(alu_func),
        .mem_data(mem_data), .mem_valid(mem_valid), .mem_req(mem_req),
        .bus_a(bus_a), .bus_b(bus_b), .ir(ir), .psr(psr), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] mrf [NTOT];
    logic [3:0]  m_psr;
    bit          m_wait;
    int          m_pend;
    logic        last_ready, last_req;

    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input int idx);
        if (idx <= 0 || idx >= NTOT) return 32'h0;
        return mrf[idx];
    endfunction

    task automatic mwrite(input int idx, input logic [31:0] v);
        if (idx > 0 && idx < NTOT) mrf[idx] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NTOT; i++) mrf[i] = 32'h0;
        m_psr  = 4'h0;
        m_wait = 1'b0;
        m_pend = 0;
    endtask

    // returns {n,z,v,c, result}
    function automatic logic [35:0] model_alu(input int f, input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        longint          ss;
        longint          sa;
        logic [31:0]     r;
        logic            v, c;
        sa = longint'($signed(a));
        ss = sa + longint'($signed(b));
        s  = longint'({32'h0, a}) + longint'({32'h0, b});
        v  = 1'b0;
        c  = 1'b0;
        r  = 32'h0;
        case (f)
            0, 5: r = a & b;
            1, 6: r = a | b;
            2, 7: r = ~(a | b);
            3, 8: begin
                r = s[31:0];
                if (f == 3) begin
                    c = s[32];
                    v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
                end
            end
            4:  r = a >> (b % 32);
            9:  r = a * 4;
            10: r = a * 1024;
            11: r = a % 8192;
            12: begin
                r = a & 32'h1FFF;
                if (a[12]) r = r - 32'h2000;
            end
            13: r = a + 1;
            14: r = a + 4;
            15: r = 32'(sa >>> 5);
            default: r = 32'h0;
        endcase
        return {r[31], (r == 32'h0), v, c, r};
    endfunction

    // One clock: compare every output against the model, then advance the model.
    task automatic tick();
        logic [31:0] irv;
        logic [35:0] alu;
        int          ai, bi, ci;
        @(negedge clk);
        irv = mrf[IRX];
        ai  = a_from_ir ? int'(irv[18:14]) : int'(a_sel);
        bi  = b_from_ir ? int'(irv[4:0])   : int'(b_sel);
        ci  = c_from_ir ? int'(irv[29:25]) : int'(c_sel);
        last_ready = uop_ready;
        last_req   = mem_req;
        check("bus_a", bus_a, mread(ai));
        check("bus_b", bus_b, mread(bi));
        check("ir", ir, irv);
        check("psr", 32'(psr), 32'(m_psr));
        check("uop_ready", 32'(uop_ready), 32'(!m_wait));
        check("mem_req", 32'(mem_req), 32'(m_wait || (uop_valid && c_src_mem)));
        if (!m_wait) begin
            if (uop_valid) begin
                if (!c_src_mem) begin
                    alu = model_alu(int'(alu_func), mread(ai), mread(bi));
                    mwrite(ci, alu[31:0]);
                    if (alu_func <= 4'd3) m_psr = alu[35:32];
                end else if (mem_valid) begin
                    mwrite(ci, mem_data);
                end else begin
                    m_wait = 1'b1;
                    m_pend = ci;
                end
            end
        end else if (mem_valid) begin
            mwrite(m_pend, mem_data);
            m_wait = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_idle();
        uop_valid = 1'b0; mem_valid = 1'b0; c_src_mem = 1'b0;
        a_from_ir = 1'b0; b_from_ir = 1'b0; c_from_ir = 1'b0;
    endtask

    task automatic op(input int a, input int b, input int c, input int f);
        drive_idle();
        a_sel = SW'(a); b_sel = SW'(b); c_sel = SW'(c); alu_func = 4'(f);
        uop_valid = 1'b1;
        tick();
        drive_idle();
    endtask

    task automatic load(input int c, input logic [31:0] d);
        drive_idle();
        c_sel = SW'(c); uop_valid = 1'b1; c_src_mem = 1'b1; mem_valid = 1'b1; mem_data = d;
        tick();
        drive_idle();
    endtask

    task automatic expect_reg(input string tag, input int idx, input logic [31:0] val);
        drive_idle();
        a_sel = SW'(idx);
        @(negedge clk);
        check(tag, bus_a, val);
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        uop_valid = 1'($urandom_range(0, 3) != 0);
        a_sel     = SW'($urandom_range(0, NSEL - 1));
        b_sel     = SW'($urandom_range(0, NSEL - 1));
        c_sel     = SW'($urandom_range(0, NSEL - 1));
        a_from_ir = 1'($urandom_range(0, 3) == 0);
        b_from_ir = 1'($urandom_range(0, 3) == 0);
        c_from_ir = 1'($urandom_range(0, 3) == 0);
        c_src_mem = 1'($urandom_range(0, 3) == 0);
        alu_func  = 4'($urandom_range(0, 15));
        mem_valid = 1'($urandom_range(0, 1));
        mem_data  = $urandom();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            randomize_inputs();
            @(negedge clk);
            check("rst_psr", 32'(psr), 32'h0);
            check("rst_ir", ir, 32'h0);
            check("rst_ready", 32'(uop_ready), 32'h1);
            check("rst_mem_req", 32'(mem_req), 32'(uop_valid && c_src_mem));
        end
        a_from_ir = 1'b0;
        for (int s = 0; s < NSEL; s++) begin
            a_sel = SW'(s);
            #0.1;
            check("rst_bus_a", bus_a, 32'h0);
        end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ready_low, req_high;
        logic [3:0] psr_snap;

        model_clear();
        apply_reset();

        // write via IR path
        load(IRX, 32'h0000_1234);
        op(0, IRX, 5, 8);
        expect_reg("r5_from_ir", 5, 32'h0000_1234);
        check("ir_value", ir, 32'h0000_1234);

        // flags
        load(1, 32'h7FFF_FFFF);
        load(2, 32'h0000_0001);
        op(1, 2, 3, 3);
        expect_reg("addcc_ovf_res", 3, 32'h8000_0000);
        check("addcc_ovf_psr", 32'(psr), 32'hA);
        load(1, 32'hFFFF_FFFF);
        op(1, 2, 4, 3);
        expect_reg("addcc_wrap_res", 4, 32'h0);
        check("addcc_wrap_psr", 32'(psr), 32'h5);
        op(1, 2, 10, 5);
        check("and_keeps_psr", 32'(psr), 32'h5);
        op(1, 2, 11, 8);
        expect_reg("add_wrap", 11, 32'h0);

        // shifts
        load(1, 32'h8000_0010);
        load(2, 32'h0000_0004);
        op(1, 0, 3, 15);
        expect_reg("rshift5", 3, 32'hFC00_0000);
        op(1, 2, 4, 4);
        expect_reg("srl", 4, 32'h0800_0001);
        load(6, 32'h0000_1000);
        op(6, 0, 8, 12);
        expect_reg("sext13", 8, 32'hFFFF_F000);

        // load stall
        psr_snap = m_psr;
        ready_low = 0;
        req_high = 0;
        drive_idle();
        c_sel = SW'(7); uop_valid = 1'b1; c_src_mem = 1'b1; mem_valid = 1'b0;
        tick();
        if (last_req) req_high++;
        for (int k = 0; k < 3; k++) begin
            randomize_inputs();
            mem_valid = 1'(k == 2);
            mem_data  = 32'hDEAD_BEEF;
            tick();
            if (!last_ready) ready_low++;
            if (last_req) req_high++;
        end
        check("stall_ready_low", 32'(ready_low), 32'd3);
        check("stall_req_high", 32'(req_high), 32'd4);
        expect_reg("stall_r7", 7, 32'hDEAD_BEEF);
        check("stall_psr", 32'(psr), 32'(psr_snap));

        // zero-latency load and r0 protection
        load(12, 32'h0000_55AA);
        expect_reg("zero_lat_r12", 12, 32'h0000_55AA);
        load(0, 32'hFFFF_FFFF);
        expect_reg("r0_protect", 0, 32'h0);

        // reset during WAIT
        drive_idle();
        c_sel = SW'(9); uop_valid = 1'b1; c_src_mem = 1'b1; mem_valid = 1'b0;
        tick();
        drive_idle();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("midwait_ready", 32'(uop_ready), 32'h1);
        check("midwait_req", 32'(mem_req), 32'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_data = 32'hCAFE_F00D;
        tick();
        expect_reg("midwait_r9", 9, 32'h0);

        // random traffic
        load(IRX, $urandom());
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            tick();
        end
        drive_idle();
        mem_valid = 1'b1;
        mem_data = $urandom();
        tick();
        drive_idle();

        // readback through the scoreboard queue
        for (int s = 0; s < NSEL; s++) exp_q.push_back(mread(s));
        for (int s = 0; s < NSEL; s++) begin
            a_sel = SW'(s);
            @(negedge clk);
            check("readback", bus_a, exp_q.pop_front());
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arc_datapath_p.md
# arc_datapath_p

Parametrised successor to the ARC datapath. It has a configurable register-file depth, data width and temporary count, a 16-function ARC ALU/shifter, and a condition-code PSR. It adds a valid/ready micro-op handshake and a memory-load wait state, so the control unit can issue micro-ops back-to-back while main-memory reads stall the datapath. It sits between the microsequencer (micro-op source) and main memory (load data source).

## Interface
- W, default 32: data width; must be at least 32, because IR fields sit at fixed bit positions.
- NREG, default 32: general registers r0..NREG-1, with r0 hardwired to 0; NREG may be at most 32.
- NTEMP, default 4: temporary registers.
- SW, default $clog2(NREG+NTEMP+2): register-select width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- uop_valid  in  1  micro-op presented this cycle.
- uop_ready  out  1  datapath accepts the micro-op; high iff FSM is IDLE.
- a_sel, b_sel, c_sel  in  SW each  register selects for buses A, B and C.
- a_from_ir, b_from_ir, c_from_ir  in  1 each  select source for the matching bus: 1 takes IR[18:14] / IR[4:0] / IR[29:25] (zero-extended), 0 takes the matching x_sel.
- c_src_mem  in  1  bus C source is memory (1) or shifter output (0).
- alu_func  in  4  ALU/shifter function.
- mem_data  in  W  main-memory read data.
- mem_valid  in  1  mem_data valid this cycle.
- mem_req  out  1  load outstanding.
- bus_a, bus_b  out  W  selected register contents, combinational.
- ir  out  W  instruction register.
- psr  out  4  {n,z,v,c}.

## Operation
- Register index map:
  - 0..NREG-1: general registers.
  - NREG: PC.
  - NREG+1..NREG+NTEMP: temporaries.
  - NREG+NTEMP+1: IR.
  - Any higher index reads 0 and ignores writes.
  - Writes to r0 are ignored.
- ALU functions (A = bus_a, B = bus_b, all results truncated to W):
  - 0 ANDCC, 1 ORCC, 2 NORCC, 3 ADDCC, 4 SRL (A >> B[$clog2(W)-1:0], logical).
  - 5 AND, 6 OR, 7 NOR, 8 ADD.
  - 9 LSHIFT2 (A<<2), 10 LSHIFT10 (A<<10).
  - 11 SIMM13 (A[12:0] zero-extended), 12 SEXT13 (A[12:0] sign-extended).
  - 13 INC (A+1), 14 INCPC (A+4), 15 RSHIFT5 (A >>> 5, arithmetic).
- PSR updates only on an accepted non-memory micro-op with func 0-3:
  - n = result[W-1]; z = (result == 0).
  - ADDCC: c = carry out of bit W-1; v = signed overflow.
  - ANDCC/ORCC/NORCC: v = c = 0.
- FSM states IDLE and WAIT:
  - IDLE, accept (uop_valid=1), c_src_mem=0: write the shifter result to the decoded C register at the edge; stay IDLE.
  - IDLE, accept, c_src_mem=1, mem_valid=1: write mem_data to the decoded C register at the edge; stay IDLE.
  - IDLE, accept, c_src_mem=1, mem_valid=0: latch the decoded C index (resolved from IR if c_from_ir); go to WAIT.
  - WAIT, mem_valid=1: write mem_data to the latched index; return to IDLE.
  - WAIT, mem_valid=0: hold; uop_ready=0; no register or PSR writes.
- Memory micro-ops never update the PSR.
- mem_req = (IDLE & uop_valid & c_src_mem) | WAIT.
- bus_a and bus_b always reflect the current select inputs, including while in WAIT.

## Timing
- Reset (rst=0, asynchronous):
  - All registers, PC, temporaries, IR and PSR go to 0; FSM goes to IDLE.
  - Outputs after reset: uop_ready=1, mem_req=0 when uop_valid=0, psr=0, ir=0.
  - Reset while in WAIT abandons the load; no write occurs.
- Non-memory micro-op: one cycle; the written value is visible on bus_a/bus_b the cycle after accept.
- Same-cycle read and write of one register: the read returns the old value (no bypass).
- Load latency: one cycle plus the number of cycles mem_valid stays low after accept. The write lands at the edge where mem_valid=1.
- The next micro-op can be accepted in the cycle after WAIT exits.
- mem_valid while IDLE with no accepted memory micro-op: ignored.
- ADD wrap-around: 0xFFFFFFFF + 1 = 0. ADDCC with the same operands gives psr = {0,1,0,1}.

## Test plan
- Reset: hold rst=0 with random inputs -> psr=0, ir=0, uop_ready=1, every bus_a select reads 0. Then write r5 = 0x1234 via ADD(r0, IR=0x1234 path) -> reading r5 next cycle gives 0x1234.
- Flags: A=0x7FFFFFFF, B=1, ADDCC -> result 0x80000000, psr={1,0,1,0}. A=0xFFFFFFFF, B=1, ADDCC -> psr={0,1,0,1}. Following AND -> psr unchanged.
- Shifts: A=0x80000010. RSHIFT5 -> 0xFC000000. SRL with B=4 -> 0x08000001. SEXT13 of 0x00001000 -> 0xFFFFF000.
- Load stall: memory micro-op to r7 with mem_valid low for 3 cycles, then mem_data=0xDEADBEEF -> uop_ready low for 3 cycles, mem_req high throughout, r7 = 0xDEADBEEF, psr unchanged.
- Zero-latency load and r0 protection: memory micro-op with mem_valid=1 in the same cycle -> single-cycle commit. Same micro-op targeting r0 -> r0 still reads 0.
- Reset mid-WAIT: assert rst during WAIT, then supply mem_valid -> no register written, FSM IDLE, mem_req=0.
